// File: rtl/serv_bus_pkg.sv
// Shared types and constants for the SERV ibus/dbus memory responder.
// Both bus channels and the top level import this package.
package serv_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } bus_state_t;

    localparam int LATW = 8;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/serv_bus_chan.sv
// One wishbone-style responder channel.
// Holds the latency FSM and request capture; the memory itself lives in the top level.
module serv_bus_chan
    import serv_bus_pkg::*;
#(
    parameter int AW  = 10,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic [31:0]   i_adr,
    input  logic [31:0]   i_dat,
    input  logic [3:0]    i_sel,
    input  logic          i_we,
    input  logic          i_cyc,
    output logic [AW-1:0] o_idx,
    output logic [31:0]   o_dat,
    output logic [3:0]    o_sel,
    output logic          o_we,
    output logic          o_load_rdt,
    output logic          o_ack,
    output logic          o_commit
);

    localparam logic [LATW-1:0] CNT_INIT = (LAT >= 2) ? LATW'(LAT - 2) : '0;

    bus_state_t      r_state;
    bus_state_t      w_next;
    logic [LATW-1:0] r_cnt;
    logic [LATW-1:0] w_cnt_next;
    logic            w_capture;

    logic [AW-1:0]   r_idx;
    logic [31:0]     r_dat;
    logic [3:0]      r_sel;
    logic            r_we;

    logic            w_unused_adr;

    assign w_unused_adr = &{1'b0, i_adr[31:AW+2], i_adr[1:0]};

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // ACK always returns to IDLE without looking at cyc, forcing an idle gap between requests.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_capture  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_cyc) begin
                    w_capture = 1'b1;
                    if (LAT <= 1) begin
                        w_next = ACK;
                    end else begin
                        w_next     = WAIT;
                        w_cnt_next = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!i_cyc) begin
                    w_next     = IDLE;
                    w_cnt_next = '0;
                end else if (r_cnt == '0) begin
                    w_next = ACK;
                end else begin
                    w_cnt_next = r_cnt - LATW'(1);
                end
            end
            ACK: begin
                w_next = IDLE;
            end
            default: begin
                w_next     = IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx <= '0;
            r_dat <= ZERO_WORD;
            r_sel <= '0;
            r_we  <= 1'b0;
        end else if (w_capture) begin
            r_idx <= i_adr[AW+1:2];
            r_dat <= i_dat;
            r_sel <= i_sel;
            r_we  <= i_we;
        end
    end

    // When LAT=1 the read happens on the capture edge, so IDLE exposes the live request fields.
    assign o_idx      = (r_state == IDLE) ? i_adr[AW+1:2] : r_idx;
    assign o_we       = (r_state == IDLE) ? i_we : r_we;
    assign o_dat      = r_dat;
    assign o_sel      = r_sel;
    assign o_load_rdt = (w_next == ACK) && (r_state != ACK);
    assign o_ack      = (r_state == ACK);
    assign o_commit   = (r_state == ACK) && r_we;

endmodule

// File: rtl/serv_bus_responder.sv
// Shared word memory answering SERV's ibus and dbus with independent latencies.
// Owns the memory array, the registered read data and the write/preload muxing.
module serv_bus_responder
    import serv_bus_pkg::*;
#(
    parameter int AW       = 10,
    parameter int IBUS_LAT = 1,
    parameter int DBUS_LAT = 2
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic [31:0]   o_ibus_adr,
    input  logic          o_ibus_cyc,
    output logic [31:0]   i_ibus_rdt,
    output logic          i_ibus_ack,
    input  logic [31:0]   o_dbus_adr,
    input  logic [31:0]   o_dbus_dat,
    input  logic [3:0]    o_dbus_sel,
    input  logic          o_dbus_we,
    input  logic          o_dbus_cyc,
    output logic [31:0]   i_dbus_rdt,
    output logic          i_dbus_ack,
    input  logic          i_ld_en,
    input  logic [AW-1:0] i_ld_adr,
    input  logic [31:0]   i_ld_dat
);

    logic [31:0]   r_mem [0:(1<<AW)-1];
    logic [31:0]   r_ibus_rdt;
    logic [31:0]   r_dbus_rdt;

    logic [AW-1:0] w_ibus_idx;
    logic [31:0]   w_ibus_dat;
    logic [3:0]    w_ibus_sel;
    logic          w_ibus_we;
    logic          w_ibus_load;
    logic          w_ibus_commit;

    logic [AW-1:0] w_dbus_idx;
    logic [31:0]   w_dbus_dat;
    logic [3:0]    w_dbus_sel;
    logic          w_dbus_we;
    logic          w_dbus_load;
    logic          w_dbus_commit;
    logic          w_ld_hits_commit;

    logic          w_unused_ibus;

    serv_bus_chan #(
        .AW  (AW),
        .LAT (IBUS_LAT)
    ) u_ibus_chan (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_adr      (o_ibus_adr),
        .i_dat      (ZERO_WORD),
        .i_sel      (4'b0000),
        .i_we       (1'b0),
        .i_cyc      (o_ibus_cyc),
        .o_idx      (w_ibus_idx),
        .o_dat      (w_ibus_dat),
        .o_sel      (w_ibus_sel),
        .o_we       (w_ibus_we),
        .o_load_rdt (w_ibus_load),
        .o_ack      (i_ibus_ack),
        .o_commit   (w_ibus_commit)
    );

    serv_bus_chan #(
        .AW  (AW),
        .LAT (DBUS_LAT)
    ) u_dbus_chan (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_adr      (o_dbus_adr),
        .i_dat      (o_dbus_dat),
        .i_sel      (o_dbus_sel),
        .i_we       (o_dbus_we),
        .i_cyc      (o_dbus_cyc),
        .o_idx      (w_dbus_idx),
        .o_dat      (w_dbus_dat),
        .o_sel      (w_dbus_sel),
        .o_we       (w_dbus_we),
        .o_load_rdt (w_dbus_load),
        .o_ack      (i_dbus_ack),
        .o_commit   (w_dbus_commit)
    );

    assign w_unused_ibus    = &{1'b0, w_ibus_dat, w_ibus_sel, w_ibus_we, w_ibus_commit};
    assign w_ld_hits_commit = i_ld_en && (i_ld_adr == w_dbus_idx);

    // A preload to the word being committed suppresses the commit so the preload wins.
    always_ff @(posedge clk) begin
        if (w_dbus_commit && !w_ld_hits_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_dbus_sel[i]) begin
                    r_mem[w_dbus_idx][8*i +: 8] <= w_dbus_dat[8*i +: 8];
                end
            end
        end
        if (i_ld_en) begin
            r_mem[i_ld_adr] <= i_ld_dat;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_ibus_rdt <= ZERO_WORD;
        end else if (w_ibus_load) begin
            r_ibus_rdt <= r_mem[w_ibus_idx];
        end else begin
            r_ibus_rdt <= ZERO_WORD;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_dbus_rdt <= ZERO_WORD;
        end else if (w_dbus_load && !w_dbus_we) begin
            r_dbus_rdt <= r_mem[w_dbus_idx];
        end else begin
            r_dbus_rdt <= ZERO_WORD;
        end
    end

    assign i_ibus_rdt = r_ibus_rdt;
    assign i_dbus_rdt = r_dbus_rdt;

endmodule
